core_rst_seq: RTL and testbench
===============================

// Module: core_rst_seq
// PURPOSE
//  Reset sequencer downstream of the APB config-register block: consumes its core_rstn level
//  (software reset request) plus a watchdog pulse, and drives staged bus/core resets.
//  Quiesces the core before asserting reset, holds reset a minimum time, then releases
//  bus reset before core reset. Sits in the always-on pclk/presetn domain beside the config block.
// PARAMETERS
//  HOLD_CYC   16   cycles both resets stay asserted (min 1)
//  GAP_CYC    8    cycles between bus_rstn release and core_rstn_o release (min 1)
//  QTMO_CYC   64   max cycles waiting for core_idle before forcing reset
//  CNT_W      8    shared down-counter width; must hold max(HOLD_CYC,GAP_CYC,QTMO_CYC)
// PORTS
//  pclk         in   1  clock
//  presetn      in   1  async active-low reset
//  sw_rstn      in   1  software reset level from config block (0 = hold core in reset)
//  wdt_rst      in   1  watchdog reset request, 1-cycle pulse
//  core_idle    in   1  core has drained outstanding bus traffic
//  quiesce_req  out  1  ask core to stop issuing transactions
//  bus_rstn     out  1  interconnect/peripheral reset, active-low
//  core_rstn_o  out  1  CPU core reset, active-low
//  rst_busy     out  1  sequence in progress (any state except RUN/HOLD_SW)
//  rst_cause    out  2  last cause: 0 POR, 1 SW, 2 WDT; sticky until next reset event
// BEHAVIOUR
//  Reset (presetn=0): state=ASSERT, cnt=HOLD_CYC-1, bus_rstn=0, core_rstn_o=0,
//   quiesce_req=0, rst_busy=1, rst_cause=POR. All outputs registered.
//  ASSERT: both resets low; cnt decrements; at cnt==0 -> if sw_rstn==0 -> HOLD_SW,
//   else -> BUS_REL (bus_rstn=1 next cycle, cnt=GAP_CYC-1).
//  HOLD_SW: resets low, rst_busy=0; sw_rstn rising -> BUS_REL.
//  BUS_REL: bus_rstn=1, core_rstn_o=0; at cnt==0 -> RUN, core_rstn_o=1.
//  RUN: both released, rst_busy=0. sw_rstn==0 -> QUIESCE (quiesce_req=1, cnt=QTMO_CYC-1),
//   cause=SW. wdt_rst -> ASSERT directly (no quiesce), cause=WDT.
//  QUIESCE: core_idle==1 or cnt==0 -> ASSERT (cnt=HOLD_CYC-1, quiesce_req=0).
//   wdt_rst here -> ASSERT immediately, cause=WDT. sw_rstn returning to 1 does NOT abort.
//  Any wdt_rst or sw_rstn==0 during BUS_REL -> ASSERT, HOLD restarts (core never ran).
//  wdt_rst during ASSERT restarts cnt=HOLD_CYC-1, cause=WDT.
//  Simultaneous wdt_rst and sw_rstn falling: WDT wins (cause=WDT, no quiesce).
//  Latency RUN->core_rstn_o low: 1 cycle (WDT); SW: QUIESCE time + 1.
//  Release after last request: HOLD_CYC + GAP_CYC cycles to core_rstn_o=1.
//  Counter never wraps: loaded on state entry, only decrements while nonzero.
// CONFIGURATION
//  CORE_RST_SEQ_SYNC_EN defined: sw_rstn, wdt_rst, core_idle each pass through a 2-flop
//   synchroniser (reset to sw_rstn=0, wdt_rst=0, core_idle=0); adds 2 cycles input latency;
//   wdt_rst must then be a level held >= 3 cycles, edge-detected after sync.
//  Undefined: inputs used directly; sources must be pclk-synchronous.
// STRUCTURE
//  Package core_rst_seq_pkg: state enum (ASSERT, HOLD_SW, BUS_REL, RUN, QUIESCE),
//   rst_cause_e (CAUSE_POR=0, CAUSE_SW=1, CAUSE_WDT=2).
//  Sub-module sync_2ff (1-bit, reset-value parameter), instantiated only under the macro.
//  FSM + single shared down-counter + cause register in top module.
// TESTING
//  POR: release presetn, sw_rstn=1 -> bus_rstn=1 at cycle 16, core_rstn_o=1 at 24, cause=0.
//  POR with sw_rstn=0 -> HOLD_SW, rst_busy=0; raise sw_rstn -> core_rstn_o=1 after 8 cycles.
//  RUN, drop sw_rstn, core_idle=1 after 5 cycles -> quiesce_req 5 cycles, then resets
//   low 16 cycles, cause=1.
//  RUN, sw_rstn=0, core_idle stuck 0 -> forced ASSERT after 64 cycles.
//  wdt_rst pulse in RUN -> core_rstn_o=0 next cycle, quiesce_req stays 0, cause=2.
//  wdt_rst same cycle as sw_rstn fall -> cause=2, no quiesce; wdt in BUS_REL -> HOLD restarts.

Source files
------------

// File: rtl/core_rst_seq_pkg.sv
// Shared types for the staged bus/core reset sequencer.
// Optional input synchronisers are enabled by CORE_RST_SEQ_SYNC_EN.
package core_rst_seq_pkg;

    typedef enum logic [2:0] {
        ASSERT,
        HOLD_SW,
        BUS_REL,
        RUN,
        QUIESCE
    } state_e;

    typedef enum logic [1:0] {
        CAUSE_POR = 2'd0,
        CAUSE_SW  = 2'd1,
        CAUSE_WDT = 2'd2
    } rst_cause_e;

    // Only the settled states report idle to software
    function automatic logic is_busy(input state_e s);
        return !(s == RUN || s == HOLD_SW);
    endfunction

endpackage

// File: rtl/core_rst_seq_sync.sv
// Single-bit two-flop synchroniser with a configurable reset value.
// Used only when CORE_RST_SEQ_SYNC_EN is defined.
module sync_2ff #(
    parameter logic RST_VAL = 1'b0
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic d_i,
    output logic q_o
);

    logic meta_q;
    logic sync_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            meta_q <= RST_VAL;
            sync_q <= RST_VAL;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule

// File: rtl/core_rst_seq.sv
// Staged reset sequencer: quiesce, hold, release bus, then release core.
// Define CORE_RST_SEQ_SYNC_EN to synchronise sw_rstn/wdt_rst/core_idle.
module core_rst_seq
    import core_rst_seq_pkg::*;
#(
    parameter int HOLD_CYC = 16,
    parameter int GAP_CYC  = 8,
    parameter int QTMO_CYC = 64,
    parameter int CNT_W    = 8
) (
    input  logic       pclk,
    input  logic       presetn,
    input  logic       sw_rstn,
    input  logic       wdt_rst,
    input  logic       core_idle,
    output logic       quiesce_req,
    output logic       bus_rstn,
    output logic       core_rstn_o,
    output logic       rst_busy,
    output logic [1:0] rst_cause
);

    localparam logic [CNT_W-1:0] HOLD_LD = CNT_W'(HOLD_CYC - 1);
    localparam logic [CNT_W-1:0] GAP_LD  = CNT_W'(GAP_CYC - 1);
    localparam logic [CNT_W-1:0] QTMO_LD = CNT_W'(QTMO_CYC - 1);

    logic sw_v;
    logic wdt_v;
    logic idle_v;

`ifdef CORE_RST_SEQ_SYNC_EN
    logic sw_s;
    logic wdt_s;
    logic idle_s;
    logic wdt_prev_q;

    sync_2ff #(.RST_VAL(1'b0)) u_sync_sw (
        .clk_i  (pclk),
        .rst_ni (presetn),
        .d_i    (sw_rstn),
        .q_o    (sw_s)
    );

    sync_2ff #(.RST_VAL(1'b0)) u_sync_wdt (
        .clk_i  (pclk),
        .rst_ni (presetn),
        .d_i    (wdt_rst),
        .q_o    (wdt_s)
    );

    sync_2ff #(.RST_VAL(1'b0)) u_sync_idle (
        .clk_i  (pclk),
        .rst_ni (presetn),
        .d_i    (core_idle),
        .q_o    (idle_s)
    );

    // Watchdog arrives as a level here; act once on its rising edge
    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            wdt_prev_q <= 1'b0;
        end else begin
            wdt_prev_q <= wdt_s;
        end
    end

    assign sw_v   = sw_s;
    assign wdt_v  = wdt_s & ~wdt_prev_q;
    assign idle_v = idle_s;
`else
    assign sw_v   = sw_rstn;
    assign wdt_v  = wdt_rst;
    assign idle_v = core_idle;
`endif

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    rst_cause_e       cause_q, cause_d;
    logic             bus_q, bus_d;
    logic             core_q, core_d;
    logic             quiesce_q, quiesce_d;
    logic             busy_q, busy_d;
    logic             cnt_zero;

    assign cnt_zero = (cnt_q == '0);

    always_comb begin
        state_d = state_q;
        cause_d = cause_q;
        cnt_d   = cnt_zero ? cnt_q : cnt_q - 1'b1;

        unique case (state_q)
            ASSERT: begin
                if (wdt_v) begin
                    cnt_d   = HOLD_LD;
                    cause_d = CAUSE_WDT;
                end else if (cnt_zero) begin
                    if (!sw_v) begin
                        state_d = HOLD_SW;
                    end else begin
                        state_d = BUS_REL;
                        cnt_d   = GAP_LD;
                    end
                end
            end
            HOLD_SW: begin
                if (wdt_v) begin
                    state_d = ASSERT;
                    cnt_d   = HOLD_LD;
                    cause_d = CAUSE_WDT;
                end else if (sw_v) begin
                    state_d = BUS_REL;
                    cnt_d   = GAP_LD;
                end
            end
            BUS_REL: begin
                // Core has not run yet, so no quiesce on abort
                if (wdt_v) begin
                    state_d = ASSERT;
                    cnt_d   = HOLD_LD;
                    cause_d = CAUSE_WDT;
                end else if (!sw_v) begin
                    state_d = ASSERT;
                    cnt_d   = HOLD_LD;
                    cause_d = CAUSE_SW;
                end else if (cnt_zero) begin
                    state_d = RUN;
                end
            end
            RUN: begin
                if (wdt_v) begin
                    state_d = ASSERT;
                    cnt_d   = HOLD_LD;
                    cause_d = CAUSE_WDT;
                end else if (!sw_v) begin
                    state_d = QUIESCE;
                    cnt_d   = QTMO_LD;
                    cause_d = CAUSE_SW;
                end
            end
            QUIESCE: begin
                if (wdt_v) begin
                    state_d = ASSERT;
                    cnt_d   = HOLD_LD;
                    cause_d = CAUSE_WDT;
                end else if (idle_v || cnt_zero) begin
                    state_d = ASSERT;
                    cnt_d   = HOLD_LD;
                end
            end
            default: begin
                state_d = ASSERT;
                cnt_d   = HOLD_LD;
            end
        endcase
    end

    // Outputs are decoded from the next state so they leave as flops
    always_comb begin
        bus_d     = (state_d == BUS_REL) || (state_d == RUN);
        core_d    = (state_d == RUN);
        quiesce_d = (state_d == QUIESCE);
        busy_d    = is_busy(state_d);
    end

    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            state_q   <= ASSERT;
            cnt_q     <= HOLD_LD;
            cause_q   <= CAUSE_POR;
            bus_q     <= 1'b0;
            core_q    <= 1'b0;
            quiesce_q <= 1'b0;
            busy_q    <= 1'b1;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            cause_q   <= cause_d;
            bus_q     <= bus_d;
            core_q    <= core_d;
            quiesce_q <= quiesce_d;
            busy_q    <= busy_d;
        end
    end

    assign bus_rstn    = bus_q;
    assign core_rstn_o = core_q;
    assign quiesce_req = quiesce_q;
    assign rst_busy    = busy_q;
    assign rst_cause   = cause_q;

endmodule

// File: tb/tb_core_rst_seq.sv
// Directed plus randomized bench for core_rst_seq against a phase/elapsed-time model.
// Exercises the default build (inputs used without synchronisers).
module tb_core_rst_seq;

    localparam int HOLD = 16;
    localparam int GAP  = 8;
    localparam int QTMO = 64;

    localparam int P_AS  = 0;
    localparam int P_HS  = 1;
    localparam int P_BR  = 2;
    localparam int P_RUN = 3;
    localparam int P_Q   = 4;

    logic       pclk = 1'b0;
    logic       presetn;
    logic       sw_rstn;
    logic       wdt_rst;
    logic       core_idle;
    logic       quiesce_req;
    logic       bus_rstn;
    logic       core_rstn_o;
    logic       rst_busy;
    logic [1:0] rst_cause;

    int nvec = 0;
    int nerr = 0;

    int m_ph;
    int m_el;
    int m_cause;

    core_rst_seq dut (
        .pclk        (pclk),
        .presetn     (presetn),
        .sw_rstn     (sw_rstn),
        .wdt_rst     (wdt_rst),
        .core_idle   (core_idle),
        .quiesce_req (quiesce_req),
        .bus_rstn    (bus_rstn),
        .core_rstn_o (core_rstn_o),
        .rst_busy    (rst_busy),
        .rst_cause   (rst_cause)
    );

    always #5 pclk = ~pclk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nvec++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic m_go(input int ph);
        m_ph = ph;
        m_el = 0;
    endtask

    // Reference: each phase lasts a fixed number of cycles unless a request intervenes
    task automatic m_step(input bit sw, input bit wdt, input bit idle);
        if (wdt) begin
            m_cause = 2;
            m_go(P_AS);
        end else begin
            case (m_ph)
                P_AS: begin
                    if (m_el + 1 >= HOLD) m_go(sw ? P_BR : P_HS);
                    else m_el++;
                end
                P_HS: if (sw) m_go(P_BR);
                P_BR: begin
                    if (!sw) begin
                        m_cause = 1;
                        m_go(P_AS);
                    end else if (m_el + 1 >= GAP) m_go(P_RUN);
                    else m_el++;
                end
                P_RUN: begin
                    if (!sw) begin
                        m_cause = 1;
                        m_go(P_Q);
                    end
                end
                default: begin
                    if (idle || m_el + 1 >= QTMO) m_go(P_AS);
                    else m_el++;
                end
            endcase
        end
    endtask

    task automatic check_model();
        chk("bus_rstn", bus_rstn, (m_ph == P_BR || m_ph == P_RUN));
        chk("core_rstn_o", core_rstn_o, (m_ph == P_RUN));
        chk("quiesce_req", quiesce_req, (m_ph == P_Q));
        chk("rst_busy", rst_busy, !(m_ph == P_RUN || m_ph == P_HS));
        chk("rst_cause", rst_cause, m_cause);
    endtask

    task automatic cycle();
        @(posedge pclk);
        m_step(sw_rstn, wdt_rst, core_idle);
        #1;
        check_model();
    endtask

    task automatic por(input bit sw);
        presetn   = 1'b0;
        sw_rstn   = sw;
        wdt_rst   = 1'b0;
        core_idle = 1'b0;
        m_go(P_AS);
        m_cause = 0;
        repeat (2) @(posedge pclk);
        #1;
        check_model();
        @(negedge pclk);
        presetn = 1'b1;
    endtask

    initial begin
        int fb;
        int fc;
        int n;
        bit sw_low;

        // POR with software reset released
        por(1'b1);
        fb = 0;
        fc = 0;
        for (int i = 1; i <= 30; i++) begin
            cycle();
            if (bus_rstn && fb == 0) fb = i;
            if (core_rstn_o && fc == 0) fc = i;
        end
        chk("por_bus_cycle", fb, 16);
        chk("por_core_cycle", fc, 24);
        chk("por_cause", rst_cause, 0);

        // Software reset, core drains after 5 cycles
        sw_rstn = 1'b0;
        n = 0;
        repeat (5) begin
            cycle();
            if (quiesce_req) n++;
        end
        chk("sw_quiesce_len", n, 5);
        core_idle = 1'b1;
        cycle();
        chk("sw_quiesce_drop", quiesce_req, 0);
        chk("sw_core_low", core_rstn_o, 0);
        core_idle = 1'b0;
        sw_rstn = 1'b1;
        n = 1;
        repeat (30) begin
            cycle();
            if (!bus_rstn) n++;
        end
        chk("sw_hold_len", n, 16);
        chk("sw_cause", rst_cause, 1);
        chk("sw_back_run", core_rstn_o, 1);

        // Software reset, core never idles: forced after the timeout
        sw_rstn = 1'b0;
        n = 0;
        repeat (100) begin
            cycle();
            if (quiesce_req) n++;
        end
        chk("qtmo_len", n, 64);
        chk("hold_sw_busy", rst_busy, 0);
        chk("hold_sw_core", core_rstn_o, 0);
        sw_rstn = 1'b1;
        cycle();
        chk("hold_sw_bus_rel", bus_rstn, 1);
        fc = 0;
        for (int i = 1; i <= 20; i++) begin
            cycle();
            if (core_rstn_o && fc == 0) fc = i;
        end
        chk("hold_sw_gap", fc, 8);

        // Watchdog in RUN
        wdt_rst = 1'b1;
        cycle();
        wdt_rst = 1'b0;
        chk("wdt_core_low", core_rstn_o, 0);
        chk("wdt_no_quiesce", quiesce_req, 0);
        chk("wdt_cause", rst_cause, 2);
        repeat (30) cycle();

        // Watchdog coincident with software reset falling
        sw_rstn = 1'b0;
        wdt_rst = 1'b1;
        cycle();
        wdt_rst = 1'b0;
        sw_rstn = 1'b1;
        chk("both_cause", rst_cause, 2);
        chk("both_no_quiesce", quiesce_req, 0);
        n = 0;
        while (!bus_rstn && n < 40) begin
            cycle();
            n++;
        end
        chk("reach_bus_rel", bus_rstn, 1);

        // Watchdog during bus release restarts the hold
        repeat (3) cycle();
        wdt_rst = 1'b1;
        cycle();
        wdt_rst = 1'b0;
        n = bus_rstn ? 0 : 1;
        repeat (30) begin
            cycle();
            if (!bus_rstn) n++;
        end
        chk("br_wdt_hold_len", n, 16);

        // POR while software holds the core in reset
        por(1'b0);
        repeat (40) cycle();
        chk("por_hs_busy", rst_busy, 0);
        chk("por_hs_bus", bus_rstn, 0);
        chk("por_hs_cause", rst_cause, 0);
        sw_rstn = 1'b1;
        repeat (12) cycle();
        chk("por_hs_run", core_rstn_o, 1);

        // Randomized traffic against the model
        sw_low = 1'b0;
        repeat (3000) begin
            if (sw_low) sw_low = ($urandom_range(0, 19) != 0);
            else sw_low = ($urandom_range(0, 59) == 0);
            sw_rstn   = !sw_low;
            wdt_rst   = ($urandom_range(0, 99) == 0);
            core_idle = ($urandom_range(0, 7) == 0);
            cycle();
        end

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
